// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared AXI-Lite read demux types and response codes
package axil_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADDR   = 2'd1,
    DATA   = 2'd2,
    DECERR = 2'd3
  } axil_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_addr_match.sv
// rtl/axil_addr_match.sv - base-address window match for one downstream port
module axil_addr_match #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    ADDR_BITS  = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE       = '0
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  hit
);

  // Only the bits above the window offset take part in the compare.
  localparam logic [ADDR_WIDTH-1:0] MASK = {ADDR_WIDTH{1'b1}} << ADDR_BITS;

  assign hit = ((addr ^ BASE) & MASK) == '0;

endmodule

// File: rtl/axil_rd_demux.sv
// rtl/axil_rd_demux.sv - AXI-Lite read demux: BRAM port 0, CSR port 1, local DECERR
module axil_rd_demux
  import axil_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] S0_BASE      = 32'h4000_0000,
  parameter int                    S0_ADDR_BITS = 12,
  parameter logic [ADDR_WIDTH-1:0] S1_BASE      = 32'h4000_1000,
  parameter int                    S1_ADDR_BITS = 8
) (
  input  logic                    axi_clock,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
  input  logic                    s_axil_arvalid,
  output logic                    s_axil_arready,
  input  logic [2:0]              s_axil_arprot,
  output logic [DATA_WIDTH-1:0]   s_axil_rdata,
  output logic [1:0]              s_axil_rresp,
  output logic                    s_axil_rvalid,
  input  logic                    s_axil_rready,
  output logic [S0_ADDR_BITS-1:0] m0_axil_araddr,
  output logic [2:0]              m0_axil_arprot,
  output logic                    m0_axil_arvalid,
  input  logic                    m0_axil_arready,
  input  logic [DATA_WIDTH-1:0]   m0_axil_rdata,
  input  logic [1:0]              m0_axil_rresp,
  input  logic                    m0_axil_rvalid,
  output logic                    m0_axil_rready,
  output logic [S1_ADDR_BITS-1:0] m1_axil_araddr,
  output logic [2:0]              m1_axil_arprot,
  output logic                    m1_axil_arvalid,
  input  logic                    m1_axil_arready,
  input  logic [DATA_WIDTH-1:0]   m1_axil_rdata,
  input  logic [1:0]              m1_axil_rresp,
  input  logic                    m1_axil_rvalid,
  output logic                    m1_axil_rready
);

  axil_state_t             state_q, state_d;
  logic                    arready_q;
  logic                    sel_q;
  logic [S0_ADDR_BITS-1:0] a0_q;
  logic [S1_ADDR_BITS-1:0] a1_q;
  logic [2:0]              prot_q;
  logic                    hit0, hit1;
  logic                    ar_fire;
  logic                    sel_arready;
  logic                    r_fire;

  axil_addr_match #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ADDR_BITS  (S0_ADDR_BITS),
    .BASE       (S0_BASE)
  ) u_match0 (
    .addr (s_axil_araddr),
    .hit  (hit0)
  );

  axil_addr_match #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ADDR_BITS  (S1_ADDR_BITS),
    .BASE       (S1_BASE)
  ) u_match1 (
    .addr (s_axil_araddr),
    .hit  (hit1)
  );

  assign s_axil_arready  = arready_q;
  assign ar_fire         = s_axil_arvalid && arready_q;
  assign m0_axil_araddr  = a0_q;
  assign m1_axil_araddr  = a1_q;
  assign m0_axil_arprot  = prot_q;
  assign m1_axil_arprot  = prot_q;
  assign sel_arready     = sel_q ? m1_axil_arready : m0_axil_arready;
  assign r_fire          = (sel_q ? m1_axil_rvalid : m0_axil_rvalid) && s_axil_rready;

  always_ff @(posedge axi_clock) begin
    if (rst) begin
      state_q   <= IDLE;
      arready_q <= 1'b0;
      sel_q     <= 1'b0;
      a0_q      <= '0;
      a1_q      <= '0;
      prot_q    <= '0;
    end else begin
      state_q   <= state_d;
      // arready is a flop so the upstream master sees a clean ready
      arready_q <= (state_d == IDLE);
      if (ar_fire) begin
        sel_q  <= !hit0;
        a0_q   <= s_axil_araddr[S0_ADDR_BITS-1:0];
        a1_q   <= s_axil_araddr[S1_ADDR_BITS-1:0];
        prot_q <= s_axil_arprot;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    m0_axil_arvalid = 1'b0;
    m1_axil_arvalid = 1'b0;
    m0_axil_rready  = 1'b0;
    m1_axil_rready  = 1'b0;
    s_axil_rvalid   = 1'b0;
    s_axil_rdata    = '0;
    s_axil_rresp    = RESP_OKAY;

    case (state_q)
      IDLE: begin
        if (ar_fire) state_d = (hit0 || hit1) ? ADDR : DECERR;
      end
      ADDR: begin
        m0_axil_arvalid = !sel_q;
        m1_axil_arvalid = sel_q;
        if (sel_arready) state_d = DATA;
      end
      DATA: begin
        if (sel_q) begin
          s_axil_rvalid  = m1_axil_rvalid;
          s_axil_rdata   = m1_axil_rdata;
          s_axil_rresp   = m1_axil_rresp;
          m1_axil_rready = s_axil_rready;
        end else begin
          s_axil_rvalid  = m0_axil_rvalid;
          s_axil_rdata   = m0_axil_rdata;
          s_axil_rresp   = m0_axil_rresp;
          m0_axil_rready = s_axil_rready;
        end
        if (r_fire) state_d = IDLE;
      end
      DECERR: begin
        s_axil_rvalid = 1'b1;
        s_axil_rresp  = RESP_DECERR;
        if (s_axil_rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axil_rd_demux.sv
// tb/tb_axil_rd_demux.sv - self-checking bench for axil_rd_demux
module tb_axil_rd_demux;

  localparam logic [31:0] S0_BASE = 32'h4000_0000;
  localparam logic [31:0] S1_BASE = 32'h4000_1000;

  logic        axi_clock = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_axil_araddr = '0;
  logic        s_axil_arvalid = 1'b0;
  logic        s_axil_arready;
  logic [2:0]  s_axil_arprot = '0;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready = 1'b0;
  logic [11:0] m0_axil_araddr;
  logic [2:0]  m0_axil_arprot;
  logic        m0_axil_arvalid;
  logic        m0_axil_arready = 1'b0;
  logic [31:0] m0_axil_rdata = '0;
  logic [1:0]  m0_axil_rresp = '0;
  logic        m0_axil_rvalid = 1'b0;
  logic        m0_axil_rready;
  logic [7:0]  m1_axil_araddr;
  logic [2:0]  m1_axil_arprot;
  logic        m1_axil_arvalid;
  logic        m1_axil_arready = 1'b0;
  logic [31:0] m1_axil_rdata = '0;
  logic [1:0]  m1_axil_rresp = '0;
  logic        m1_axil_rvalid = 1'b0;
  logic        m1_axil_rready;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int acc_cyc = 0;

  axil_rd_demux dut (
    .axi_clock       (axi_clock),
    .rst             (rst),
    .s_axil_araddr   (s_axil_araddr),
    .s_axil_arvalid  (s_axil_arvalid),
    .s_axil_arready  (s_axil_arready),
    .s_axil_arprot   (s_axil_arprot),
    .s_axil_rdata    (s_axil_rdata),
    .s_axil_rresp    (s_axil_rresp),
    .s_axil_rvalid   (s_axil_rvalid),
    .s_axil_rready   (s_axil_rready),
    .m0_axil_araddr  (m0_axil_araddr),
    .m0_axil_arprot  (m0_axil_arprot),
    .m0_axil_arvalid (m0_axil_arvalid),
    .m0_axil_arready (m0_axil_arready),
    .m0_axil_rdata   (m0_axil_rdata),
    .m0_axil_rresp   (m0_axil_rresp),
    .m0_axil_rvalid  (m0_axil_rvalid),
    .m0_axil_rready  (m0_axil_rready),
    .m1_axil_araddr  (m1_axil_araddr),
    .m1_axil_arprot  (m1_axil_arprot),
    .m1_axil_arvalid (m1_axil_arvalid),
    .m1_axil_arready (m1_axil_arready),
    .m1_axil_rdata   (m1_axil_rdata),
    .m1_axil_rresp   (m1_axil_rresp),
    .m1_axil_rvalid  (m1_axil_rvalid),
    .m1_axil_rready  (m1_axil_rready)
  );

  always #5 axi_clock = ~axi_clock;
  always @(posedge axi_clock) cycle <= cycle + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge axi_clock);
    #1;
  endtask

  // Reference decode by address range: 0 = BRAM, 1 = CSR, -1 = unmapped
  function automatic int model_port(input logic [31:0] addr);
    if (addr >= S0_BASE && addr < S0_BASE + 32'h1000) return 0;
    if (addr >= S1_BASE && addr < S1_BASE + 32'h100) return 1;
    return -1;
  endfunction

  // Upstream noise while busy: must never be accepted
  task automatic junk;
    s_axil_arvalid = 1'($urandom);
    s_axil_araddr  = $urandom;
  endtask

  task automatic read_txn(input logic [31:0] addr, input int ar_lat, input int r_lat,
                          input int rr_lat, input logic [31:0] data, input logic [1:0] resp);
    int          port;
    logic [31:0] loc;
    logic [2:0]  prot;
    logic        rv, rr;
    port = model_port(addr);
    prot = 3'($urandom);
    chk("arready_idle", s_axil_arready, 1);
    s_axil_araddr  = addr;
    s_axil_arprot  = prot;
    s_axil_arvalid = 1'b1;
    acc_cyc = cycle;
    tick;
    s_axil_arvalid = 1'b0;
    if (port < 0) begin
      for (int i = 0; i <= rr_lat; i++) begin
        junk();
        s_axil_rready = (i == rr_lat);
        chk("decerr_rvalid", s_axil_rvalid, 1);
        chk("decerr_rresp", s_axil_rresp, 2'b11);
        chk("decerr_rdata", s_axil_rdata, 0);
        chk("decerr_m0_arvalid", m0_axil_arvalid, 0);
        chk("decerr_m1_arvalid", m1_axil_arvalid, 0);
        chk("decerr_arready", s_axil_arready, 0);
        tick;
      end
    end else begin
      loc = addr - (port == 1 ? S1_BASE : S0_BASE);
      for (int i = 0; i <= ar_lat; i++) begin
        junk();
        m0_axil_arready = (port == 0) && (i == ar_lat);
        m1_axil_arready = (port == 1) && (i == ar_lat);
        chk("arvalid_sel", port == 1 ? m1_axil_arvalid : m0_axil_arvalid, 1);
        chk("arvalid_other", port == 1 ? m0_axil_arvalid : m1_axil_arvalid, 0);
        chk("araddr_local", port == 1 ? 64'(m1_axil_araddr) : 64'(m0_axil_araddr),
            port == 1 ? 64'(loc & 32'hFF) : 64'(loc & 32'hFFF));
        chk("arprot_fwd", port == 1 ? m1_axil_arprot : m0_axil_arprot, prot);
        chk("addr_rvalid", s_axil_rvalid, 0);
        chk("addr_arready", s_axil_arready, 0);
        tick;
      end
      m0_axil_arready = 1'b0;
      m1_axil_arready = 1'b0;
      for (int i = 0; i <= r_lat + rr_lat; i++) begin
        junk();
        rv = (i >= r_lat);
        rr = (i < r_lat) ? 1'($urandom) : (i == r_lat + rr_lat);
        if (port == 1) begin
          m1_axil_rvalid = rv; m1_axil_rdata = data; m1_axil_rresp = resp;
        end else begin
          m0_axil_rvalid = rv; m0_axil_rdata = data; m0_axil_rresp = resp;
        end
        s_axil_rready = rr;
        #1;
        chk("data_rvalid", s_axil_rvalid, rv);
        if (rv) begin
          chk("data_rdata", s_axil_rdata, data);
          chk("data_rresp", s_axil_rresp, resp);
        end
        chk("rready_sel", port == 1 ? m1_axil_rready : m0_axil_rready, rr);
        chk("rready_other", port == 1 ? m0_axil_rready : m1_axil_rready, 0);
        chk("data_arvalid", m0_axil_arvalid | m1_axil_arvalid, 0);
        chk("data_arready", s_axil_arready, 0);
        tick;
      end
      m0_axil_rvalid = 1'b0;
      m1_axil_rvalid = 1'b0;
    end
    s_axil_rready  = 1'b0;
    s_axil_arvalid = 1'b0;
  endtask

  initial begin
    int          prev;
    logic [31:0] addr;
    repeat (3) tick;
    chk("rst_arready", s_axil_arready, 0);
    chk("rst_arvalid", {m0_axil_arvalid, m1_axil_arvalid}, 0);
    chk("rst_rready", {m0_axil_rready, m1_axil_rready}, 0);
    chk("rst_rvalid", s_axil_rvalid, 0);
    chk("rst_rdata", s_axil_rdata, 0);
    chk("rst_rresp", s_axil_rresp, 0);
    chk("rst_araddr", {m0_axil_araddr, m1_axil_araddr}, 0);
    rst = 1'b0;
    tick;

    read_txn(32'h4000_0010, 0, 2, 0, 32'hDEAD_BEEF, 2'b00);
    read_txn(32'h4000_1004, 0, 0, 0, 32'h0000_00A5, 2'b00);
    read_txn(32'h5000_0000, 0, 0, 0, 32'h0, 2'b00);
    read_txn(32'h4000_0040, 3, 0, 5, 32'h1234_5678, 2'b00);

    prev = 0;
    for (int k = 0; k < 4; k++) begin
      read_txn(S0_BASE + 32'(k * 4), 0, 0, 0, 32'hA000_0000 + 32'(k), 2'b00);
      if (k > 0) chk("b2b_spacing", 64'(acc_cyc - prev), 3);
      prev = acc_cyc;
    end

    // Reset while in DATA, slave not yet responding
    s_axil_araddr = 32'h4000_0020; s_axil_arvalid = 1'b1;
    tick;
    s_axil_arvalid = 1'b0; m0_axil_arready = 1'b1;
    tick;
    m0_axil_arready = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrst_arvalid", {m0_axil_arvalid, m1_axil_arvalid}, 0);
    chk("midrst_rvalid", s_axil_rvalid, 0);
    chk("midrst_rready", {m0_axil_rready, m1_axil_rready}, 0);
    chk("midrst_arready", s_axil_arready, 0);
    tick;
    read_txn(32'h4000_0000, 1, 1, 1, 32'h0BAD_F00D, 2'b00);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 6))
        0: addr = S0_BASE + ($urandom & 32'hFFF);
        1: addr = S1_BASE + ($urandom & 32'hFF);
        2: addr = S0_BASE + 32'hFFC;
        3: addr = S1_BASE + 32'h100;
        4: addr = S0_BASE - 32'h4;
        5: addr = S1_BASE + 32'hFF;
        default: addr = $urandom;
      endcase
      read_txn(addr, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom, $urandom_range(0, 1) == 1 ? 2'b10 : 2'b00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
